// File: rtl/dram_cache_pkg.sv
// Shared widths, FSM states and byte-enable helper for the DRAM line cache.
package dram_cache_pkg;

    localparam int LINE_BITS     = 128;
    localparam int ADDR_BITS     = 29;
    localparam int LINE_OFF_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_t;

    // Place a 4-bit word strobe onto the 16-bit line byte enable.
    function automatic logic [15:0] byte_en(input logic [1:0] off,
                                            input logic [3:0] strb);
        return 16'(strb) << (4 * off);
    endfunction

endpackage

// File: rtl/dram_cache_ram.sv
// Line data and tag storage: asynchronous read, byte-masked single write port.
module cache_line_ram
    import dram_cache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int TAG   = 19
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [15:0]              be,
    input  logic [$clog2(LINES)-1:0] addr,
    input  logic [LINE_BITS-1:0]     wdata,
    input  logic [TAG-1:0]           wtag,
    output logic [LINE_BITS-1:0]     rdata,
    output logic [TAG-1:0]           rtag
);

    logic [LINE_BITS-1:0] data_mem [LINES];
    logic [TAG-1:0]       tag_mem  [LINES];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 16; b++) begin
                if (be[b]) data_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
            tag_mem[addr] <= wtag;
        end
    end

    assign rdata = data_mem[addr];
    assign rtag  = tag_mem[addr];

endmodule

// File: rtl/dram_cache.sv
// Direct-mapped write-back cache turning CPU word/byte accesses into
// 128-bit line fills and write-backs on the dram_control handshake.
module dram_cache
    import dram_cache_pkg::*;
#(
    parameter int LINES = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cpu_valid,
    output logic                 cpu_ready,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [3:0]           cpu_wstrb,
    input  logic [31:0]          cpu_wdata,
    output logic [31:0]          cpu_rdata,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_wmask,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata
);

    localparam int IDX = $clog2(LINES);
    localparam int TAG = 25 - IDX;

    state_t state, state_d;

    logic [LINES-1:0] vld, dirty;

    logic [1:0]     off;
    logic [IDX-1:0] idx;
    logic [TAG-1:0] tag;
    logic           unused_bits;

    assign off         = cpu_addr[3:2];
    assign idx         = cpu_addr[4 +: IDX];
    assign tag         = cpu_addr[ADDR_BITS-1:4+IDX];
    assign unused_bits = ^cpu_addr[1:0];

    logic [LINE_BITS-1:0] line;
    logic [TAG-1:0]       line_tag;
    logic                 hit, req;

    assign hit = vld[idx] && (line_tag == tag);
    // The ready cycle itself never starts a new request.
    assign req = cpu_valid && !cpu_ready;

    logic                 we, fill, set_dirty, clr_dirty;
    logic [15:0]          be;
    logic [LINE_BITS-1:0] wdata;
    logic                 cpu_ready_d, mem_valid_d, mem_wmask_d;
    logic [31:0]          cpu_rdata_d;
    logic [ADDR_BITS-1:0] mem_addr_d;
    logic [LINE_BITS-1:0] mem_wdata_d;

    cache_line_ram #(
        .LINES (LINES),
        .TAG   (TAG)
    ) u_ram (
        .clk   (clk),
        .we    (we && rstn),
        .be    (be),
        .addr  (idx),
        .wdata (wdata),
        .wtag  (tag),
        .rdata (line),
        .rtag  (line_tag)
    );

    always_comb begin
        state_d     = state;
        we          = 1'b0;
        fill        = 1'b0;
        set_dirty   = 1'b0;
        clr_dirty   = 1'b0;
        be          = '0;
        wdata       = line;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata;
        mem_valid_d = mem_valid;
        mem_wmask_d = mem_wmask;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        unique case (state)
            IDLE: begin
                if (req && hit) begin
                    cpu_ready_d = 1'b1;
                    if (cpu_wstrb == 4'b0) begin
                        cpu_rdata_d = line[32*off +: 32];
                    end else begin
                        we        = 1'b1;
                        be        = byte_en(off, cpu_wstrb);
                        wdata     = {4{cpu_wdata}};
                        set_dirty = 1'b1;
                    end
                end else if (req && vld[idx] && dirty[idx]) begin
                    state_d     = WB;
                    mem_valid_d = 1'b1;
                    mem_wmask_d = 1'b1;
                    mem_addr_d  = {line_tag, idx, 4'b0};
                    mem_wdata_d = line;
                end else if (req) begin
                    state_d     = FILL;
                    mem_valid_d = 1'b1;
                    mem_wmask_d = 1'b0;
                    mem_addr_d  = {tag, idx, 4'b0};
                end
            end
            WB: begin
                if (mem_valid && mem_ready) begin
                    mem_valid_d = 1'b0;
                    clr_dirty   = 1'b1;
                    state_d     = FILL;
                end
            end
            FILL: begin
                // After a write-back the fill launches once valid has dropped.
                if (!mem_valid) begin
                    mem_valid_d = 1'b1;
                    mem_wmask_d = 1'b0;
                    mem_addr_d  = {tag, idx, 4'b0};
                end else if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    we          = 1'b1;
                    be          = '1;
                    wdata       = mem_rdata;
                    fill        = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            vld       <= '0;
            dirty     <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            mem_valid <= 1'b0;
            mem_wmask <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_d;
            cpu_ready <= cpu_ready_d;
            cpu_rdata <= cpu_rdata_d;
            mem_valid <= mem_valid_d;
            mem_wmask <= mem_wmask_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if (fill) begin
                vld[idx]   <= 1'b1;
                dirty[idx] <= 1'b0;
            end
            if (set_dirty) dirty[idx] <= 1'b1;
            if (clr_dirty) dirty[idx] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dram_cache.sv
// Directed bench for dram_cache: bench plays both CPU and DRAM controller.
module tb_dram_cache;

    logic         clk;
    logic         rstn;
    logic         cpu_valid;
    logic         cpu_ready;
    logic [28:0]  cpu_addr;
    logic [3:0]   cpu_wstrb;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         mem_valid;
    logic         mem_ready;
    logic [28:0]  mem_addr;
    logic         mem_wmask;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;
    logic stable;

    localparam logic [127:0] L1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] L2 = 128'h44444444_33333333_22222222_11111111;

    dram_cache #(.LINES(64)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cpu_valid (cpu_valid),
        .cpu_ready (cpu_ready),
        .cpu_addr  (cpu_addr),
        .cpu_wstrb (cpu_wstrb),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive(input logic [28:0] a, input logic [3:0] s,
                         input logic [31:0] d);
        cpu_valid = 1'b1;
        cpu_addr  = a;
        cpu_wstrb = s;
        cpu_wdata = d;
    endtask

    initial begin
        rstn = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; cpu_wstrb = '0;
        cpu_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        cyc(); cyc();
        chk("rst_cpu_ready", 128'(cpu_ready), 0);
        chk("rst_cpu_rdata", 128'(cpu_rdata), 0);
        chk("rst_mem_valid", 128'(mem_valid), 0);
        chk("rst_mem_addr", 128'(mem_addr), 0);
        chk("rst_mem_wmask", 128'(mem_wmask), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rstn = 1'b1;
        cyc();

        // Cold read of 0x100
        drive(29'h100, 4'b0, 32'h0);
        cyc();
        chk("cold_mem_valid", 128'(mem_valid), 1);
        chk("cold_mem_addr", 128'(mem_addr), 128'h100);
        chk("cold_mem_wmask", 128'(mem_wmask), 0);
        chk("cold_no_ready", 128'(cpu_ready), 0);
        mem_ready = 1'b1; mem_rdata = L1;
        cyc();
        mem_ready = 1'b0; mem_rdata = '0;
        chk("cold_valid_drop", 128'(mem_valid), 0);
        chk("cold_ready_early", 128'(cpu_ready), 0);
        cyc();
        chk("cold_ready", 128'(cpu_ready), 1);
        chk("cold_rdata", 128'(cpu_rdata), 128'hAAAAAAAA);
        cpu_valid = 1'b0;
        cyc();

        // Hit read of 0x104
        drive(29'h104, 4'b0, 32'h0);
        cyc();
        chk("hit104_ready", 128'(cpu_ready), 1);
        chk("hit104_rdata", 128'(cpu_rdata), 128'hBBBBBBBB);
        chk("hit104_no_mem", 128'(mem_valid), 0);
        cpu_valid = 1'b0;
        cyc();

        // Write hit 0x108 strobe 0101
        drive(29'h108, 4'b0101, 32'h11223344);
        cyc();
        chk("wr108_ready", 128'(cpu_ready), 1);
        chk("wr108_no_mem", 128'(mem_valid), 0);
        chk("wr108_rdata_held", 128'(cpu_rdata), 128'hBBBBBBBB);
        cpu_valid = 1'b0;
        cyc();
        drive(29'h108, 4'b0, 32'h0);
        cyc();
        chk("rd108_ready", 128'(cpu_ready), 1);
        chk("rd108_rdata", 128'(cpu_rdata), 128'hCC22CC44);
        chk("rd108_no_mem", 128'(mem_valid), 0);
        cpu_valid = 1'b0;
        cyc();

        // Conflict read of 0x500: dirty write-back, slow ready
        drive(29'h500, 4'b0, 32'h0);
        cyc();
        chk("wb_valid", 128'(mem_valid), 1);
        chk("wb_wmask", 128'(mem_wmask), 1);
        chk("wb_addr", 128'(mem_addr), 128'h100);
        chk("wb_word2", 128'(mem_wdata[95:64]), 128'hCC22CC44);
        chk("wb_line", mem_wdata, 128'hDDDDDDDD_CC22CC44_BBBBBBBB_AAAAAAAA);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (mem_valid !== 1'b1 || mem_addr !== 29'h100 ||
                mem_wmask !== 1'b1 || cpu_ready !== 1'b0) stable = 1'b0;
        end
        chk("wb_stable_20", 128'(stable), 1);
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        chk("wb_drop", 128'(mem_valid), 0);
        cyc();
        chk("fill2_valid", 128'(mem_valid), 1);
        chk("fill2_addr", 128'(mem_addr), 128'h500);
        chk("fill2_wmask", 128'(mem_wmask), 0);
        mem_ready = 1'b1; mem_rdata = L2;
        cyc();
        mem_ready = 1'b0; mem_rdata = '0;
        chk("fill2_drop", 128'(mem_valid), 0);
        cyc();
        chk("fill2_ready", 128'(cpu_ready), 1);
        chk("fill2_rdata", 128'(cpu_rdata), 128'h11111111);
        cpu_valid = 1'b0;
        cyc();

        // Spurious mem_ready while idle
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        cyc();
        chk("spur_mem_valid", 128'(mem_valid), 0);
        chk("spur_cpu_ready", 128'(cpu_ready), 0);

        // Dirty write, then reset
        drive(29'h500, 4'b1111, 32'hDEADBEEF);
        cyc();
        chk("wr500_ready", 128'(cpu_ready), 1);
        cpu_valid = 1'b0;
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        chk("rst2_cpu_ready", 128'(cpu_ready), 0);
        chk("rst2_cpu_rdata", 128'(cpu_rdata), 0);
        chk("rst2_mem_valid", 128'(mem_valid), 0);
        chk("rst2_mem_addr", 128'(mem_addr), 0);
        chk("rst2_mem_wdata", mem_wdata, 0);
        cyc();
        drive(29'h500, 4'b0, 32'h0);
        cyc();
        chk("rst_fill_valid", 128'(mem_valid), 1);
        chk("rst_fill_wmask", 128'(mem_wmask), 0);
        chk("rst_fill_addr", 128'(mem_addr), 128'h500);
        mem_ready = 1'b1; mem_rdata = L2;
        cyc();
        mem_ready = 1'b0; mem_rdata = '0;
        cyc();
        chk("rst_fill_ready", 128'(cpu_ready), 1);
        chk("rst_fill_rdata", 128'(cpu_rdata), 128'h11111111);
        cpu_valid = 1'b0;
        cyc();

        // Hold cpu_valid across cpu_ready
        drive(29'h504, 4'b0, 32'h0);
        cyc();
        chk("hold_ready1", 128'(cpu_ready), 1);
        chk("hold_rdata1", 128'(cpu_rdata), 128'h22222222);
        cyc();
        chk("hold_no_double", 128'(cpu_ready), 0);
        cyc();
        chk("hold_reaccept", 128'(cpu_ready), 1);
        chk("hold_no_mem", 128'(mem_valid), 0);
        cpu_valid = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
